// File: rtl/sdsu_bus_slave.sv
// Responder end of the SDSU single-channel bus: 2^ADDR_W x DATA_W register file, one write+read per handshake.
// Latency: ready pulses after edge E0+WAIT_CYCLES+1; back-to-back period WAIT_CYCLES+3; inputs ignored once accepted.
module sdsu_bus_slave #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] WAddr,
    input  logic [DATA_W-1:0] WData,
    input  logic [ADDR_W-1:0] RAddr,
    output logic [DATA_W-1:0] RData,
    output logic              ready
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_raddr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [NREG];

    logic              w_wait_done;
    logic              w_collide;
    logic [DATA_W-1:0] w_rd_value;

    // The acceptance cycle itself counts as one capture cycle, so WAIT holds
    // for WAIT_CYCLES+1 cycles and even WAIT_CYCLES=0 responds after E0+1.
    assign w_wait_done = (r_cnt == CNT_W'(WAIT_CYCLES));

    // Write-first: a read of the address being written returns the new data.
    assign w_collide  = (r_raddr == r_waddr);
    assign w_rd_value = w_collide ? r_wdata : r_mem[r_raddr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_raddr <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (valid) begin
                        r_waddr <= WAddr;
                        r_wdata <= WData;
                        r_raddr <= RAddr;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_mem[r_waddr] <= r_wdata;
                        r_rdata        <= w_rd_value;
                        r_ready        <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // RData is held; only the strobe drops.
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RData = r_rdata;
    assign ready = r_ready;

endmodule
